upstream_write_sequencer: RTL

//  Upstream stage that produces the ack/memwr handshake consumed by the downstream processor FSM.
//  - Buffers incoming write requests in a small FIFO.
//  - For each request it pulses ack, drives the memory write for MEM_LAT cycles, then pulses memwr.
//  - Holds off a new ack while the downstream stage reports busy (its out signal).

---
 rtl/ws_pkg.sv | 14 +
 rtl/ws_fifo.sv | 63 ++++++
 rtl/upstream_write_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/ws_pkg.sv
// Shared types and constants for the upstream write sequencer.
package ws_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACK   = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Cycles the ack handshake pulse is held high.
    localparam int unsigned ACK_PULSE = 1;

endpackage

// File: rtl/ws_fifo.sv
// Request buffer: registered pointers and count, combinational head read, no fall-through.
module ws_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 40
) (
    input  logic                    clk,
    input  logic                    HRESET,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (HRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/upstream_write_sequencer.sv
// Buffers write requests and sequences each one as ack pulse, MEM_LAT write cycles, memwr pulse.
module upstream_write_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MEM_LAT    = 3
) (
    input  logic                           clk,
    input  logic                           HRESET,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [DATA_W-1:0]              req_data,
    input  logic                           dn_busy,
    output logic                           ack,
    output logic                           memwr,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

    import ws_pkg::*;

    localparam int unsigned ENT_W = ADDR_W + DATA_W;
    localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ENT_W-1:0]  head;
    logic              fifo_full, fifo_empty, pop;

    ws_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk    (clk),
        .HRESET (HRESET),
        .push   (req_valid & req_ready),
        .pop    (pop),
        .din    ({req_addr, req_data}),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign req_ready = ~fifo_full;

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                // dn_busy only gates the start of a write, never one already in flight.
                if (!fifo_empty && !dn_busy) begin
                    state_d     = ACK;
                    pop         = 1'b1;
                    lat_cnt_d   = '0;
                    mem_addr_d  = head[ENT_W-1:DATA_W];
                    mem_wdata_d = head[DATA_W-1:0];
                end
            end
            ACK: begin
                if (lat_cnt_q == LAT_W'(ACK_PULSE - 1)) begin
                    state_d   = WRITE;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            WRITE: begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                if (lat_cnt_q == LAT_W'(MEM_LAT - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (HRESET) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ack       = (state_q == ACK);
    assign mem_we    = (state_q == WRITE);
    assign memwr     = (state_q == DONE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
